// File: rtl/seg_counter_display.sv
// seg_counter_display: prescaled hex/BCD up/down counter with parallel load and active-low 7-seg decode.
// Optional leading-zero blanking is compiled in when SEG_COUNTER_LZ_BLANK_EN is defined.
module seg_counter_display #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 33554432,
    parameter int BCD      = 0
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                EN,
    input  logic                UP,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] LOAD_VAL,
    output logic [4*DIGITS-1:0] COUNT,
    output logic                TICK,
    output logic                WRAP,
    output logic [7*DIGITS-1:0] HEX
);
    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    DMAX     = (BCD != 0) ? 4'd9 : 4'd15;

    logic [PW-1:0]       pre;
    logic                pre_last;
    logic                step;
    logic                carry;
    logic [3:0]          d;
    logic [4*DIGITS-1:0] count_nxt;
    logic [4*DIGITS-1:0] load_sat;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h18;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign pre_last = (pre == PRE_LAST);
    assign step     = EN & ~LOAD & pre_last;

    // Per-digit ripple serves both hex and BCD; carry/borrow out of the top digit marks a wrap.
    always_comb begin
        count_nxt = COUNT;
        carry     = 1'b1;
        d         = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = COUNT[4*i +: 4];
            if (carry) begin
                if (UP) begin
                    if (d == DMAX) d = 4'd0;
                    else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) d = DMAX;
                    else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            count_nxt[4*i +: 4] = d;
        end
    end

    always_comb begin
        load_sat = LOAD_VAL;
        if (BCD != 0) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (LOAD_VAL[4*i +: 4] > 4'd9) load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            pre   <= '0;
            COUNT <= '0;
            TICK  <= 1'b0;
            WRAP  <= 1'b0;
        end else if (LOAD) begin
            pre   <= '0;
            COUNT <= load_sat;
            TICK  <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            if (EN) pre <= pre_last ? '0 : pre + 1'b1;
            if (step) COUNT <= count_nxt;
            TICK <= step;
            WRAP <= step & carry;
        end
    end

`ifdef SEG_COUNTER_LZ_BLANK_EN
    logic lz;

    // Scan from the most-significant digit; digit 0 always shows so a zero count reads "0".
    always_comb begin
        HEX = '1;
        lz  = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            lz = lz & (COUNT[4*(DIGITS-1-j) +: 4] == 4'd0);
            if (lz && (j != DIGITS - 1)) HEX[7*(DIGITS-1-j) +: 7] = 7'h7F;
            else HEX[7*(DIGITS-1-j) +: 7] = seg7(COUNT[4*(DIGITS-1-j) +: 4]);
        end
    end
`else
    always_comb begin
        HEX = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            HEX[7*i +: 7] = seg7(COUNT[4*i +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_seg_counter_display.sv
// Directed bench for seg_counter_display: 2-digit hex and BCD instances (TICK_DIV=4)
// and a 3-digit hex instance (TICK_DIV=1) for display and every-cycle stepping.
module tb_seg_counter_display;
`ifdef SEG_COUNTER_LZ_BLANK_EN
    localparam logic [6:0] BH = 7'h7F;
`else
    localparam logic [6:0] BH = 7'h40;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_en, a_up, a_load, a_tick, a_wrap;
    logic [7:0]  a_val, a_count;
    logic [13:0] a_hex;
    logic        b_reset, b_en, b_up, b_load, b_tick, b_wrap;
    logic [7:0]  b_val, b_count;
    logic [13:0] b_hex;
    logic        c_reset, c_en, c_up, c_load, c_tick, c_wrap;
    logic [11:0] c_val, c_count;
    logic [20:0] c_hex;

    int nvec = 0;
    int nerr = 0;

    seg_counter_display #(.DIGITS(2), .TICK_DIV(4), .BCD(0)) dut_hex (
        .CLOCK_50(clk), .RESET(a_reset), .EN(a_en), .UP(a_up), .LOAD(a_load),
        .LOAD_VAL(a_val), .COUNT(a_count), .TICK(a_tick), .WRAP(a_wrap), .HEX(a_hex));

    seg_counter_display #(.DIGITS(2), .TICK_DIV(4), .BCD(1)) dut_bcd (
        .CLOCK_50(clk), .RESET(b_reset), .EN(b_en), .UP(b_up), .LOAD(b_load),
        .LOAD_VAL(b_val), .COUNT(b_count), .TICK(b_tick), .WRAP(b_wrap), .HEX(b_hex));

    seg_counter_display #(.DIGITS(3), .TICK_DIV(1), .BCD(0)) dut_3 (
        .CLOCK_50(clk), .RESET(c_reset), .EN(c_en), .UP(c_up), .LOAD(c_load),
        .LOAD_VAL(c_val), .COUNT(c_count), .TICK(c_tick), .WRAP(c_wrap), .HEX(c_hex));

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        nvec++; if (a_count !== 8'h00) begin nerr++; $display("FAIL rst_count: got %h want 00", a_count); end
        nvec++; if ({a_tick, a_wrap} !== 2'b00) begin nerr++; $display("FAIL rst_tick_wrap: got %b want 00", {a_tick, a_wrap}); end
        nvec++; if (a_hex !== {BH, 7'h40}) begin nerr++; $display("FAIL rst_hex: got %h want %h", a_hex, {BH, 7'h40}); end
        nvec++; if (b_count !== 8'h00) begin nerr++; $display("FAIL rst_bcd_count: got %h want 00", b_count); end
        nvec++; if (c_hex !== {BH, BH, 7'h40}) begin nerr++; $display("FAIL rst_hex3: got %h want %h", c_hex, {BH, BH, 7'h40}); end
    endtask

    task automatic test_count_up();
        logic [6:0] segs [4] = '{7'h40, 7'h79, 7'h24, 7'h30};
        logic [7:0] ec;
        logic       et;
        a_en = 1'b1; a_up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ec = 8'(k / 4);
            et = (k % 4 == 0);
            nvec++; if (a_count !== ec) begin nerr++; $display("FAIL up_count[%0d]: got %h want %h", k, a_count, ec); end
            nvec++; if (a_tick !== et) begin nerr++; $display("FAIL up_tick[%0d]: got %b want %b", k, a_tick, et); end
            nvec++; if (a_wrap !== 1'b0) begin nerr++; $display("FAIL up_wrap[%0d]: got %b want 0", k, a_wrap); end
            nvec++; if (a_hex !== {BH, segs[k/4]}) begin nerr++; $display("FAIL up_hex[%0d]: got %h want %h", k, a_hex, {BH, segs[k/4]}); end
        end
    endtask

    task automatic test_hex_wrap();
        a_load = 1'b1; a_val = 8'hFF; a_up = 1'b1; a_en = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        nvec++; if (a_count !== 8'hFF || a_tick !== 1'b0) begin nerr++; $display("FAIL hw_load: got %h/%b want ff/0", a_count, a_tick); end
        repeat (3) begin
            @(negedge clk);
            nvec++; if (a_count !== 8'hFF || a_tick !== 1'b0) begin nerr++; $display("FAIL hw_hold: got %h/%b want ff/0", a_count, a_tick); end
        end
        @(negedge clk);
        nvec++; if (a_count !== 8'h00) begin nerr++; $display("FAIL hw_up_count: got %h want 00", a_count); end
        nvec++; if ({a_tick, a_wrap} !== 2'b11) begin nerr++; $display("FAIL hw_up_flags: got %b want 11", {a_tick, a_wrap}); end
        nvec++; if (a_hex !== {BH, 7'h40}) begin nerr++; $display("FAIL hw_up_hex: got %h want %h", a_hex, {BH, 7'h40}); end
        @(negedge clk);
        nvec++; if ({a_tick, a_wrap} !== 2'b00) begin nerr++; $display("FAIL hw_pulse_end: got %b want 00", {a_tick, a_wrap}); end
        a_load = 1'b1; a_val = 8'h00; a_up = 1'b0;
        @(negedge clk);
        a_load = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        nvec++; if (a_count !== 8'hFF) begin nerr++; $display("FAIL hw_dn_count: got %h want ff", a_count); end
        nvec++; if ({a_tick, a_wrap} !== 2'b11) begin nerr++; $display("FAIL hw_dn_flags: got %b want 11", {a_tick, a_wrap}); end
        nvec++; if (a_hex !== {7'h0E, 7'h0E}) begin nerr++; $display("FAIL hw_dn_hex: got %h want 070e", a_hex); end
        a_load = 1'b1; a_val = 8'hAF; a_en = 1'b0;
        @(negedge clk);
        a_load = 1'b0;
        nvec++; if (a_hex !== {7'h08, 7'h0E}) begin nerr++; $display("FAIL hw_af_hex: got %h want %h", a_hex, {7'h08, 7'h0E}); end
    endtask

    task automatic test_bcd();
        logic [7:0] lv [4] = '{8'h19, 8'h99, 8'h20, 8'h00};
        logic       uv [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] ev [4] = '{8'h20, 8'h00, 8'h19, 8'h99};
        logic       wv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        b_en = 1'b1;
        for (int v = 0; v < 4; v++) begin
            b_load = 1'b1; b_val = lv[v]; b_up = uv[v];
            @(negedge clk);
            b_load = 1'b0;
            repeat (3) @(negedge clk);
            @(negedge clk);
            nvec++; if (b_count !== ev[v]) begin nerr++; $display("FAIL bcd_count[%0d]: got %h want %h", v, b_count, ev[v]); end
            nvec++; if ({b_tick, b_wrap} !== {1'b1, wv[v]}) begin nerr++; $display("FAIL bcd_flags[%0d]: got %b want %b", v, {b_tick, b_wrap}, {1'b1, wv[v]}); end
        end
        nvec++; if (b_hex !== {7'h18, 7'h18}) begin nerr++; $display("FAIL bcd_hex99: got %h want %h", b_hex, {7'h18, 7'h18}); end
        b_en = 1'b0; b_up = 1'b0;
        repeat (4) @(negedge clk);
        nvec++; if (b_count !== 8'h99) begin nerr++; $display("FAIL bcd_hold: got %h want 99", b_count); end
        b_load = 1'b1; b_val = 8'hAF;
        @(negedge clk);
        nvec++; if (b_count !== 8'h99) begin nerr++; $display("FAIL bcd_sat_af: got %h want 99", b_count); end
        b_val = 8'h5A;
        @(negedge clk);
        b_load = 1'b0;
        nvec++; if (b_count !== 8'h59) begin nerr++; $display("FAIL bcd_sat_5a: got %h want 59", b_count); end
    endtask

    task automatic test_load_on_step();
        a_load = 1'b1; a_val = 8'h00; a_en = 1'b1; a_up = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        repeat (3) @(negedge clk);
        a_load = 1'b1; a_val = 8'h42;
        @(negedge clk);
        a_load = 1'b0;
        nvec++; if (a_count !== 8'h42) begin nerr++; $display("FAIL ls_count: got %h want 42", a_count); end
        nvec++; if ({a_tick, a_wrap} !== 2'b00) begin nerr++; $display("FAIL ls_flags: got %b want 00", {a_tick, a_wrap}); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            nvec++; if (a_count !== 8'h42 || a_tick !== 1'b0) begin nerr++; $display("FAIL ls_wait[%0d]: got %h/%b want 42/0", k, a_count, a_tick); end
        end
        @(negedge clk);
        nvec++; if (a_count !== 8'h43 || a_tick !== 1'b1) begin nerr++; $display("FAIL ls_step: got %h/%b want 43/1", a_count, a_tick); end
    endtask

    task automatic test_pause_reset();
        a_load = 1'b1; a_val = 8'h10; a_en = 1'b1; a_up = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        repeat (2) @(negedge clk);
        a_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nvec++; if (a_count !== 8'h10 || a_tick !== 1'b0 || a_hex !== {7'h79, 7'h40}) begin
                nerr++; $display("FAIL pause[%0d]: got %h/%b/%h want 10/0/%h", k, a_count, a_tick, a_hex, {7'h79, 7'h40});
            end
        end
        a_en = 1'b1;
        @(negedge clk);
        nvec++; if (a_count !== 8'h10 || a_tick !== 1'b0) begin nerr++; $display("FAIL resume_pre3: got %h/%b want 10/0", a_count, a_tick); end
        @(negedge clk);
        nvec++; if (a_count !== 8'h11 || a_tick !== 1'b1) begin nerr++; $display("FAIL resume_step: got %h/%b want 11/1", a_count, a_tick); end
        a_load = 1'b1; a_val = 8'h37;
        @(negedge clk);
        a_load = 1'b0;
        repeat (2) @(negedge clk);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        nvec++; if (a_count !== 8'h00 || {a_tick, a_wrap} !== 2'b00) begin nerr++; $display("FAIL midrst: got %h/%b want 00/00", a_count, {a_tick, a_wrap}); end
        repeat (3) begin
            @(negedge clk);
            nvec++; if (a_count !== 8'h00 || a_tick !== 1'b0) begin nerr++; $display("FAIL midrst_wait: got %h/%b want 00/0", a_count, a_tick); end
        end
        @(negedge clk);
        nvec++; if (a_count !== 8'h01 || a_tick !== 1'b1) begin nerr++; $display("FAIL midrst_step: got %h/%b want 01/1", a_count, a_tick); end
    endtask

    task automatic test_display3();
        logic [11:0] lv [3] = '{12'h005, 12'h000, 12'h100};
        logic [20:0] hv [3];
        hv[0] = {BH, BH, 7'h12};
        hv[1] = {BH, BH, 7'h40};
        hv[2] = {7'h79, 7'h40, 7'h40};
        c_en = 1'b0;
        for (int v = 0; v < 3; v++) begin
            c_load = 1'b1; c_val = lv[v];
            @(negedge clk);
            nvec++; if (c_hex !== hv[v]) begin nerr++; $display("FAIL disp3[%0d]: got %h want %h", v, c_hex, hv[v]); end
        end
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        @(negedge clk);
        nvec++; if (c_count !== 12'h101 || c_tick !== 1'b1 || c_hex !== {7'h79, 7'h40, 7'h79}) begin
            nerr++; $display("FAIL div1_step1: got %h/%b/%h want 101/1/%h", c_count, c_tick, c_hex, {7'h79, 7'h40, 7'h79});
        end
        @(negedge clk);
        nvec++; if (c_count !== 12'h102 || c_tick !== 1'b1) begin nerr++; $display("FAIL div1_step2: got %h/%b want 102/1", c_count, c_tick); end
        c_load = 1'b1; c_val = 12'h000; c_up = 1'b0;
        @(negedge clk);
        c_load = 1'b0;
        @(negedge clk);
        nvec++; if (c_count !== 12'hFFF || {c_tick, c_wrap} !== 2'b11) begin nerr++; $display("FAIL div1_dnwrap: got %h/%b want fff/11", c_count, {c_tick, c_wrap}); end
    endtask

    initial begin
        a_reset = 1'b0; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_val = '0;
        b_reset = 1'b0; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_val = '0;
        c_reset = 1'b0; c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_val = '0;
        @(negedge clk);
        test_reset();
        test_count_up();
        test_hex_wrap();
        test_bcd();
        test_load_on_step();
        test_pause_reset();
        test_display3();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
